// File: rtl/evt_status_rdlatch_if.sv
// Bus between the event/CPU side and evt_status_rdlatch: event pulses, irq mask,
// read/clear strobes in; read snapshot, qualifier and interrupt out.
interface evt_status_rdlatch_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
);
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] en;
  logic             rd;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic [CNTW-1:0]  miss;
  logic             dvalid;
  logic             irq;

  modport master (output ev, en, rd, clr, input dout, miss, dvalid, irq);
  modport slave  (input ev, en, rd, clr, output dout, miss, dvalid, irq);
endinterface

// File: rtl/evt_status_rdlatch.sv
// Sticky event status with read-to-clear, saturating lost-event counter and a
// masked level interrupt. Reads return a snapshot one clock after rd.
module evt_status_rdlatch #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  evt_status_rdlatch_if.slave  bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] status_next;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_next;
  logic             hit;

  logic [WIDTH-1:0] dout_p1;
  logic [CNTW-1:0]  miss_p1;
  logic             vld_p1;
  logic             irq_p1;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNTW'(1);
  endfunction

  // clr beats rd beats ev; a miss only counts on a plain accumulate cycle
  always_comb begin
    status_next = status | bus.ev;
    cnt_next    = cnt;
    hit         = |(status & bus.ev);
    if (bus.clr) begin
      status_next = '0;
      cnt_next    = '0;
    end else if (bus.rd) begin
      status_next = bus.ev;
      cnt_next    = '0;
    end else if (hit) begin
      cnt_next    = sat_inc(cnt);
    end
  end

  // p0 -> p1: state update and registered read snapshot / interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status  <= '0;
      cnt     <= '0;
      dout_p1 <= '0;
      miss_p1 <= '0;
      vld_p1  <= 1'b0;
      irq_p1  <= 1'b0;
    end else begin
      status <= status_next;
      cnt    <= cnt_next;
      vld_p1 <= bus.rd;
      irq_p1 <= |(status_next & bus.en);
      if (bus.rd) begin
        dout_p1 <= status;
        miss_p1 <= cnt;
      end
    end
  end

  assign bus.dout   = dout_p1;
  assign bus.miss   = miss_p1;
  assign bus.dvalid = vld_p1;
  assign bus.irq    = irq_p1;

endmodule

// File: tb/tb_evt_status_rdlatch.sv
// Bench for evt_status_rdlatch: directed scenarios plus random traffic, two
// instances (8-bit and 2-bit counters) checked against a behavioural model.
module tb_evt_status_rdlatch;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  evt_status_rdlatch_if #(.WIDTH(W), .CNTW(8)) ifa ();
  evt_status_rdlatch_if #(.WIDTH(W), .CNTW(2)) ifb ();

  assign ifb.ev  = ifa.ev;
  assign ifb.en  = ifa.en;
  assign ifb.rd  = ifa.rd;
  assign ifb.clr = ifa.clr;

  evt_status_rdlatch #(.WIDTH(W), .CNTW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  evt_status_rdlatch #(.WIDTH(W), .CNTW(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model: set of pending bits, number of miss cycles since last
  // read/clear (unbounded, saturated only when compared), last read snapshot
  logic [W-1:0] m_pend;
  int           m_misses;
  logic [W-1:0] m_dout;
  int           m_snap_misses;
  logic         m_dvalid;
  logic         m_irq;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_misses = 0; m_dout = '0; m_snap_misses = 0;
    m_dvalid = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] ev, input logic [W-1:0] en,
                            input logic rd, input logic clr);
    if (rd) begin
      m_dout        = m_pend;
      m_snap_misses = m_misses;
    end
    m_dvalid = rd;
    if (clr) begin
      m_pend = '0; m_misses = 0;
    end else if (rd) begin
      m_pend = ev; m_misses = 0;
    end else begin
      if ((m_pend & ev) != '0) m_misses = m_misses + 1;
      m_pend = m_pend | ev;
    end
    m_irq = ((m_pend & en) != '0);
  endtask

  task automatic compare_all();
    chk("a_dout",   32'(ifa.dout),   32'(m_dout));
    chk("a_miss",   32'(ifa.miss),   32'(sat(m_snap_misses, 255)));
    chk("a_dvalid", 32'(ifa.dvalid), 32'(m_dvalid));
    chk("a_irq",    32'(ifa.irq),    32'(m_irq));
    chk("b_dout",   32'(ifb.dout),   32'(m_dout));
    chk("b_miss",   32'(ifb.miss),   32'(sat(m_snap_misses, 3)));
    chk("b_dvalid", 32'(ifb.dvalid), 32'(m_dvalid));
    chk("b_irq",    32'(ifb.irq),    32'(m_irq));
  endtask

  // called at a negedge: drive, let the edge happen, compare on the next negedge
  task automatic step(input logic [W-1:0] ev, input logic [W-1:0] en,
                      input logic rd, input logic clr);
    ifa.ev = ev; ifa.en = en; ifa.rd = rd; ifa.clr = clr;
    @(posedge clk);
    model_edge(ev, en, rd, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic [W-1:0] en);
    for (int i = 0; i < n; i++) step('0, en, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_all();
    end
    ifa.ev = '0; ifa.rd = 1'b0; ifa.clr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ev_r, en_r;
    logic         rd_r, clr_r;
    rst_n = 1'b0;
    ifa.ev = '0; ifa.en = '0; ifa.rd = 1'b0; ifa.clr = 1'b0;
    model_reset();
    @(negedge clk);

    // reset then idle
    do_reset(3);
    idle(5, '0);
    chk("lit_idle_dout", 32'(ifa.dout), 32'h0);
    chk("lit_idle_irq",  32'(ifa.irq),  32'h0);

    // single event raises irq, read returns it and drops irq
    step(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("lit_single_irq", 32'(ifa.irq), 32'h1);
    step('0, 16'h0001, 1'b1, 1'b0);
    chk("lit_single_dout",   32'(ifa.dout),   32'h0001);
    chk("lit_single_miss",   32'(ifa.miss),   32'h0);
    chk("lit_single_dvalid", 32'(ifa.dvalid), 32'h1);
    chk("lit_single_irq0",   32'(ifa.irq),    32'h0);
    idle(1, 16'h0001);
    chk("lit_single_dvalid0", 32'(ifa.dvalid), 32'h0);

    // miss counting: 4 pulses -> 3 misses
    for (int i = 0; i < 4; i++) begin
      step(16'h0004, '0, 1'b0, 1'b0);
      idle(1, '0);
    end
    step('0, '0, 1'b1, 1'b0);
    chk("lit_miss4_dout", 32'(ifa.dout), 32'h0004);
    chk("lit_miss4_cnt",  32'(ifa.miss), 32'd3);

    // 6 pulses -> 5 misses, 2-bit counter saturates at 3
    for (int i = 0; i < 6; i++) step(16'h0004, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("lit_miss6_a", 32'(ifa.miss), 32'd5);
    chk("lit_miss6_b", 32'(ifb.miss), 32'd3);

    // read/event collision keeps the new event for the next read
    step(16'h0010, '0, 1'b0, 1'b0);
    step(16'h0010, '0, 1'b1, 1'b0);
    chk("lit_coll_dout1", 32'(ifa.dout), 32'h0010);
    chk("lit_coll_miss1", 32'(ifa.miss), 32'h0);
    step('0, '0, 1'b1, 1'b0);
    chk("lit_coll_dout2",   32'(ifa.dout),   32'h0010);
    chk("lit_coll_dvalid2", 32'(ifa.dvalid), 32'h1);

    // clear priority over rd and ev
    step(16'h00FF, 16'h01FF, 1'b0, 1'b0);
    chk("lit_clr_irq_pre", 32'(ifa.irq), 32'h1);
    step(16'h0100, 16'h01FF, 1'b1, 1'b1);
    chk("lit_clr_dout",   32'(ifa.dout),   32'h00FF);
    chk("lit_clr_dvalid", 32'(ifa.dvalid), 32'h1);
    chk("lit_clr_irq",    32'(ifa.irq),    32'h0);
    step('0, 16'h01FF, 1'b1, 1'b0);
    chk("lit_clr_dout2", 32'(ifa.dout), 32'h0000);
    chk("lit_clr_miss2", 32'(ifa.miss), 32'h0);
    chk("lit_clr_irq2",  32'(ifa.irq),  32'h0);

    // reset lands while a read is pending: read aborted, status gone
    step(16'h0300, '0, 1'b0, 1'b0);
    ifa.rd = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compare_all();
      chk("lit_abort_dvalid", 32'(ifa.dvalid), 32'h0);
    end
    ifa.rd = 1'b0;
    rst_n = 1'b1;
    idle(1, '0);
    chk("lit_abort_dvalid_post", 32'(ifa.dvalid), 32'h0);
    step('0, '0, 1'b1, 1'b0);
    chk("lit_abort_dout", 32'(ifa.dout), 32'h0);

    // random traffic; phase 1 has no reads so the 8-bit counter saturates
    en_r = 16'(($urandom));
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 700; i++) begin
        ev_r  = 16'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 3) == 0) ev_r = '0;
        if ($urandom_range(0, 19) == 0) en_r = 16'($urandom);
        rd_r  = (ph != 1) && ($urandom_range(0, 5) == 0);
        clr_r = (ph == 2) && ($urandom_range(0, 29) == 0);
        if (ph == 2 && $urandom_range(0, 4) == 0) rd_r = 1'b1;
        step(ev_r, en_r, rd_r, clr_r);
        if (ph == 0 && $urandom_range(0, 299) == 0) do_reset(1);
      end
      if (ph == 1) begin
        step('0, en_r, 1'b1, 1'b0);
        chk("lit_sat_a", 32'(ifa.miss), 32'd255);
        chk("lit_sat_b", 32'(ifb.miss), 32'd3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
